// File: rtl/ram_dump.sv
// ram_dump: walks a synchronous RAM from address 0 to LAST_ADDR and presents
// each word on a valid/ready output port, with optional seven-segment digits
// showing the current address and data.
// Optional feature macro: RAM_DUMP_HEX_EN (builds the hex digit decoders;
// without it the three digit outputs are driven blank, 7'h7F).
// The RAM read port is treated as registered: the word is captured two edges
// after the read strobe edge, so every word takes four cycles
// (READ, two WAIT cycles, PRESENT).
module ram_dump #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int LAST_ADDR = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [6:0]        addr_hex,
  output logic [6:0]        data_hi_hex,
  output logic [6:0]        data_lo_hex
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wait_q, wait_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // Next-state, counter and capture logic for the dump sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // First WAIT cycle lets the registered RAM output settle; capture on the second.
        if (wait_q) begin
          data_d  = ram_q;
          addr_d  = cnt_q;
          state_d = PRESENT;
        end else begin
          wait_d  = 1'b1;
          state_d = WAIT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = FIN;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = READ;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      wait_q  <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // Status outputs decode straight from the state register (glitch-free).
  assign ram_addr  = cnt_q;
  assign ram_rden  = (state_q == READ);
  assign out_valid = (state_q == PRESENT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_data  = data_q;
  assign out_addr  = addr_q;

`ifdef RAM_DUMP_HEX_EN
  // Active-low seven-segment glyph for one nibble, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      4'hF:    hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  assign addr_hex    = hex7(addr_q[3:0]);
  assign data_hi_hex = hex7(data_q[7:4]);
  assign data_lo_hex = hex7(data_q[3:0]);
`else
  assign addr_hex    = 7'h7F;
  assign data_hi_hex = 7'h7F;
  assign data_lo_hex = 7'h7F;
`endif

endmodule

// File: tb/tb_ram_dump.sv
// Scoreboard bench for ram_dump: expected {addr,data} pairs are queued when a
// dump is launched; a negedge monitor pops one per accepted transfer.
module tb_ram_dump;

  logic       clk = 1'b0;
  logic       clear, start, out_ready;
  logic [3:0] ram_addr, out_addr;
  logic       ram_rden, out_valid, busy, done;
  logic [7:0] ram_q = 8'h00;
  logic [7:0] out_data;
  logic [6:0] addr_hex, data_hi_hex, data_lo_hex;

  logic [7:0]  mem [16];
  logic [11:0] exp_q [$];
  int          tq [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          xfer_cnt = 0;

  ram_dump #(.ADDR_W(4), .DATA_W(8), .LAST_ADDR(15)) dut (
    .clock(clk), .clear(clear), .start(start),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_q(ram_q),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
    .addr_hex(addr_hex), .data_hi_hex(data_hi_hex), .data_lo_hex(data_lo_hex)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, output holds until the next read.
  always @(posedge clk) if (ram_rden) ram_q <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [11:0] e;
    if (out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", {20'd0, out_addr, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_addr", {28'd0, out_addr}, {28'd0, e[11:8]});
        chk("xfer_data", {24'd0, out_data}, {24'd0, e[7:0]});
      end
      xfer_cnt++;
      tq.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i[3:0], mem[i]});
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_hex(input logic [6:0] a, input logic [6:0] h, input logic [6:0] l);
`ifdef RAM_DUMP_HEX_EN
    chk("addr_hex", {25'd0, addr_hex}, {25'd0, a});
    chk("data_hi_hex", {25'd0, data_hi_hex}, {25'd0, h});
    chk("data_lo_hex", {25'd0, data_lo_hex}, {25'd0, l});
`else
    chk("addr_hex_blank", {25'd0, addr_hex}, {25'd0, 7'h7F});
    chk("data_hi_hex_blank", {25'd0, data_hi_hex}, {25'd0, 7'h7F});
    chk("data_lo_hex_blank", {25'd0, data_lo_hex}, {25'd0, 7'h7F});
    if (a == h && h == l && a == 7'h00) chk("hex_unused", 32'd0, 32'd0);
`endif
  endtask

  // Wait for word idx, optionally stall it, then accept it with a one-cycle ready.
  task automatic accept_one(input int idx, input int stall);
    bit ok;
    wait_valid(ok);
    if (idx == 14) check_hex(7'h06, 7'h30, 7'h46);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, {24'd0, mem[idx]});
      chk("hold_addr", {28'd0, out_addr}, idx);
      chk("hold_no_rden", {31'd0, ram_rden}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rden"}, {31'd0, ram_rden}, 32'd0);
    chk({tag, "_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_oaddr"}, {28'd0, out_addr}, 32'd0);
    chk({tag, "_raddr"}, {28'd0, ram_addr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, x0;
    bit ok;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    clear = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    check_hex(7'h40, 7'h40, 7'h40);
    clear = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Full dump with ready tied high: order, latency, spacing, single done.
    tq.delete();
    push_words(16);
    d0 = done_cnt; x0 = xfer_cnt;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("read_rden", {31'd0, ram_rden}, 32'd1);
    chk("read_busy", {31'd0, busy}, 32'd1);
    k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    chk("start_latency", k, 32'd3);
    wait_done(200);
    tick();
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_done_count", done_cnt - d0, 32'd1);
    chk("t1_xfer_count", xfer_cnt - x0, 32'd16);
    chk("t1_queue_empty", exp_q.size(), 32'd0);
    if (tq.size() == 16) begin
      for (int i = 1; i < 16; i++) chk("xfer_spacing", tq[i] - tq[i-1], 32'd4);
    end else begin
      chk("t1_spacing_samples", tq.size(), 32'd16);
    end

    // Stall on address 5 for ten cycles; word 14 carries 3C for the digits.
    mem[14] = 8'h3C;
    push_words(16);
    d0 = done_cnt;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) accept_one(i, (i == 5) ? 10 : 0);
    wait_done(20);
    tick();
    chk("t2_done_count", done_cnt - d0, 32'd1);
    chk("t2_queue_empty", exp_q.size(), 32'd0);
    mem[14] = 8'hAE;

    // Clear while presenting address 7, with start and ready also asserted.
    push_words(7);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) accept_one(i, 0);
    wait_valid(ok);
    chk("t3_at_addr7", {28'd0, out_addr}, 32'd7);
    d0 = done_cnt;
    clear = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    check_reset_outputs("clear");
    clear = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (5) tick();
    chk("t3_stays_idle", {31'd0, busy}, 32'd0);
    chk("t3_no_done", done_cnt - d0, 32'd0);
    chk("t3_queue_empty", exp_q.size(), 32'd0);

    // Start held high throughout: one pass from address 0, no restart from FIN.
    push_words(16);
    d0 = done_cnt; x0 = xfer_cnt;
    out_ready = 1'b1;
    start = 1'b1;
    wait_done(200);
    tick();
    chk("t4_idle_after_fin", {31'd0, busy}, 32'd0);
    start = 1'b0;
    tick();
    chk("t4_still_idle", {31'd0, busy}, 32'd0);
    chk("t4_done_count", done_cnt - d0, 32'd1);
    chk("t4_xfer_count", xfer_cnt - x0, 32'd16);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
